// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and multi-cycle FPU sequencer for the 5-stage RV32F pipeline.
// Drives the enables and flushes of PC, IF/ID, ID/EX and EX/MEM. It resolves
// load-use hazards (integer and FP register classes) and branch/jump redirects.
// It also freezes the pipe while an iterative FDIV/FSQRT occupies EX.
//
// Ports
//   clk, rst                          clock, async active-low reset
//   id_rs{1,2,3}_addr, id_rs{1,2}_float, id_rs3_used   ID source operands
//   ex_rd_addr, ex_regW_en, ex_rsW_float, ex_mem_rd      EX destination / load
//   ex_fpu_op                         00 none, 01 FDIV, 10 FSQRT, 11 as 00
//   ex_redirect                       taken branch or jump in EX
//   pc_en, if_id_en, id_ex_en, ex_mem_en          register enables
//   if_id_flush, id_ex_flush, ex_mem_flush        bubble insertion
//   fpu_start, fpu_busy, fpu_result_valid         iterative unit strobes
//   stall_cycles                      cycles with pc_en low (optional counter)
//
// Optional build macro: HAZ_STALL_CNT_EN enables the saturating stall counter.
// When the macro is undefined, stall_cycles is tied to zero and the counter
// flops are not built.
//
// FPU sequencer states
//   state | meaning
//   IDLE  | no iterative op in flight; a new FDIV/FSQRT in EX starts here
//   BUSY  | iterative unit working, pipe frozen, cnt counts down to 1
//   DONE  | result valid, EX/MEM captures it this cycle, pipe runs

module pipe_hazard_ctrl #(
    parameter int FDIV_CYCLES  = 12,
    parameter int FSQRT_CYCLES = 16,
    parameter int CNT_W        = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  id_rs3_addr,
    input  logic        id_rs1_float,
    input  logic        id_rs2_float,
    input  logic        id_rs3_used,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_regW_en,
    input  logic        ex_rsW_float,
    input  logic        ex_mem_rd,
    input  logic [1:0]  ex_fpu_op,
    input  logic        ex_redirect,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        fpu_start,
    output logic        fpu_busy,
    output logic        fpu_result_valid,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Detect cycle and DONE cycle are not counted, so BUSY lasts LAT-2 cycles.
    localparam logic [CNT_W-1:0] FDIV_LOAD  = CNT_W'(FDIV_CYCLES - 2);
    localparam logic [CNT_W-1:0] FSQRT_LOAD = CNT_W'(FSQRT_CYCLES - 2);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic op_div, op_sqrt;
    logic rs1_hit, rs2_hit, rs3_hit, load_use;

    assign op_div  = (ex_fpu_op == 2'b01);
    assign op_sqrt = (ex_fpu_op == 2'b10);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        fpu_start        = 1'b0;
        fpu_busy         = 1'b0;
        fpu_result_valid = 1'b0;
        case (state)
            IDLE: begin
                if (op_div || op_sqrt) begin
                    fpu_start = 1'b1;
                    fpu_busy  = 1'b1;
                    cnt_nxt   = op_div ? FDIV_LOAD : FSQRT_LOAD;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                fpu_busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                // The op is still in EX this cycle; return to IDLE without
                // looking at it so it does not start a second time.
                fpu_result_valid = 1'b1;
                state_nxt        = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Integer x0 is hardwired zero and never forwards a hazard; FP f0 is a real register.
    assign rs1_hit = (id_rs1_float == ex_rsW_float) && (id_rs1_addr == ex_rd_addr);
    assign rs2_hit = (id_rs2_float == ex_rsW_float) && (id_rs2_addr == ex_rd_addr);
    assign rs3_hit = id_rs3_used && ex_rsW_float && (id_rs3_addr == ex_rd_addr);

    assign load_use = ex_mem_rd && ex_regW_en
                      && !(!ex_rsW_float && (ex_rd_addr == 5'd0))
                      && (rs1_hit || rs2_hit || rs3_hit);

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (fpu_busy) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (!pc_en && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus a randomized run
// against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int FDIV_LAT  = 12;
    localparam int FSQRT_LAT = 16;

    // {pc,if_id,id_ex,ex_mem enables, if_id,id_ex,ex_mem flushes, start, busy, valid}
    localparam logic [9:0] V_RUN    = 10'b1111_000_000;
    localparam logic [9:0] V_START  = 10'b0000_001_110;
    localparam logic [9:0] V_BUSY   = 10'b0000_001_010;
    localparam logic [9:0] V_DONE   = 10'b1111_000_001;
    localparam logic [9:0] V_LDUSE  = 10'b0011_010_000;
    localparam logic [9:0] V_REDIR  = 10'b1111_110_000;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rs3_addr;
    logic        id_rs1_float, id_rs2_float, id_rs3_used;
    logic [4:0]  ex_rd_addr;
    logic        ex_regW_en, ex_rsW_float, ex_mem_rd;
    logic [1:0]  ex_fpu_op;
    logic        ex_redirect;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush;
    logic        fpu_start, fpu_busy, fpu_result_valid;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] obs;
    assign obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
                  ex_mem_flush, fpu_start, fpu_busy, fpu_result_valid};

    pipe_hazard_ctrl #(.FDIV_CYCLES(FDIV_LAT), .FSQRT_CYCLES(FSQRT_LAT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rs3_addr(id_rs3_addr),
        .id_rs1_float(id_rs1_float), .id_rs2_float(id_rs2_float), .id_rs3_used(id_rs3_used),
        .ex_rd_addr(ex_rd_addr), .ex_regW_en(ex_regW_en), .ex_rsW_float(ex_rsW_float),
        .ex_mem_rd(ex_mem_rd), .ex_fpu_op(ex_fpu_op), .ex_redirect(ex_redirect),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .fpu_start(fpu_start), .fpu_busy(fpu_busy), .fpu_result_valid(fpu_result_valid),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rs3_addr = 5'd0;
        id_rs1_float = 1'b0; id_rs2_float = 1'b0; id_rs3_used = 1'b0;
        ex_rd_addr = 5'd0; ex_regW_en = 1'b0; ex_rsW_float = 1'b0; ex_mem_rd = 1'b0;
        ex_fpu_op = 2'b00; ex_redirect = 1'b0;
    endtask

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Load in EX followed by an ID consumer in the given classes.
    task automatic set_load(input logic [4:0] rd, input logic rd_fp);
        ex_rd_addr = rd; ex_rsW_float = rd_fp; ex_regW_en = 1'b1; ex_mem_rd = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        #2;
        rst = 1'b0;
        #3;
        if (obs !== V_RUN) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, V_RUN);
        end
        n_checks++;
        if (stall_cycles !== 32'd0) begin
            n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cycles);
        end
        n_checks++;
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        if (obs !== V_RUN) begin
            n_fail++; $display("FAIL reset_released_idle: got %b want %b", obs, V_RUN);
        end
        n_checks++;
    endtask

    task automatic test_load_use();
        do_reset();
        next_cycle();
        set_load(5'd5, 1'b0);
        id_rs1_addr = 5'd5; id_rs2_addr = 5'd7;
        @(negedge clk);
        if (obs !== V_LDUSE) begin
            n_fail++; $display("FAIL load_use_bubble: got %b want %b", obs, V_LDUSE);
        end
        n_checks++;
        next_cycle();
        ex_mem_rd = 1'b0; ex_regW_en = 1'b0;
        @(negedge clk);
        if (obs !== V_RUN) begin
            n_fail++; $display("FAIL load_use_after: got %b want %b", obs, V_RUN);
        end
        n_checks++;
        next_cycle();
        set_load(5'd5, 1'b1);
        id_rs1_addr = 5'd5; id_rs1_float = 1'b0;
        @(negedge clk);
        if (obs !== V_RUN) begin
            n_fail++; $display("FAIL class_mismatch: got %b want %b", obs, V_RUN);
        end
        n_checks++;
        next_cycle();
        set_load(5'd0, 1'b0);
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
        @(negedge clk);
        if (obs !== V_RUN) begin
            n_fail++; $display("FAIL x0_no_stall: got %b want %b", obs, V_RUN);
        end
        n_checks++;
        next_cycle();
        set_load(5'd0, 1'b1);
        id_rs1_float = 1'b1; id_rs2_addr = 5'd3;
        @(negedge clk);
        if (obs !== V_LDUSE) begin
            n_fail++; $display("FAIL f0_stalls: got %b want %b", obs, V_LDUSE);
        end
        n_checks++;
        next_cycle();
        drive_idle();
        set_load(5'd9, 1'b1);
        id_rs1_addr = 5'd1; id_rs2_addr = 5'd2; id_rs3_addr = 5'd9; id_rs3_used = 1'b1;
        @(negedge clk);
        if (obs !== V_LDUSE) begin
            n_fail++; $display("FAIL rs3_stalls: got %b want %b", obs, V_LDUSE);
        end
        n_checks++;
        next_cycle();
        drive_idle();
    endtask

    task automatic test_fdiv();
        logic [9:0] want;
        do_reset();
        next_cycle();
        ex_fpu_op = 2'b01;
        for (int c = 1; c <= FDIV_LAT; c++) begin
            want = (c == 1) ? V_START : ((c == FDIV_LAT) ? V_DONE : V_BUSY);
            @(negedge clk);
            if (obs !== want) begin
                n_fail++; $display("FAIL fdiv_cycle_%0d: got %b want %b", c, obs, want);
            end
            n_checks++;
            next_cycle();
        end
        ex_fpu_op = 2'b00;
        @(negedge clk);
        if (obs !== V_RUN) begin
            n_fail++; $display("FAIL fdiv_after: got %b want %b", obs, V_RUN);
        end
        n_checks++;
`ifdef HAZ_STALL_CNT_EN
        if (stall_cycles !== 32'd11) begin
            n_fail++; $display("FAIL fdiv_stall_cnt: got %0d want 11", stall_cycles);
        end
`else
        if (stall_cycles !== 32'd0) begin
            n_fail++; $display("FAIL fdiv_stall_cnt: got %0d want 0", stall_cycles);
        end
`endif
        n_checks++;
        next_cycle();
    endtask

    task automatic test_redirect_priority();
        do_reset();
        next_cycle();
        set_load(5'd6, 1'b0);
        id_rs2_addr = 5'd6;
        ex_redirect = 1'b1;
        @(negedge clk);
        if (obs !== V_REDIR) begin
            n_fail++; $display("FAIL redirect_over_load_use: got %b want %b", obs, V_REDIR);
        end
        n_checks++;
        next_cycle();
        drive_idle();
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        next_cycle();
        ex_fpu_op = 2'b10;
        // cycle 1 is the start cycle, cycles 2..6 are BUSY; reset lands in the 5th BUSY cycle
        for (int c = 1; c < 6; c++) next_cycle();
        rst = 1'b0;
        ex_fpu_op = 2'b00;
        @(negedge clk);
        if (obs !== V_RUN) begin
            n_fail++; $display("FAIL reset_mid_busy: got %b want %b", obs, V_RUN);
        end
        n_checks++;
        rst = 1'b1;
        for (int c = 0; c < FSQRT_LAT + 2; c++) begin
            next_cycle();
            @(negedge clk);
            if (obs !== V_RUN) begin
                n_fail++; $display("FAIL after_reset_busy_%0d: got %b want %b", c, obs, V_RUN);
            end
            n_checks++;
        end
    endtask

    // Behavioural model: the FPU is tracked as a count of remaining frozen
    // cycles plus a pending-result flag; hazards follow the priority rules.
    task automatic test_random();
        int          busy_left;
        bit          done_pend;
        longint      stalls;
        logic [9:0]  want;
        bit          e_start, e_busy, e_valid, hit;
        bit          srcs_fp [3];
        logic [4:0]  srcs_ad [3];
        bit          srcs_on [3];
        do_reset();
        busy_left = 0; done_pend = 0; stalls = 0;
        for (int c = 0; c < 600; c++) begin
            next_cycle();
            id_rs1_addr  = 5'($urandom_range(0, 3));
            id_rs2_addr  = 5'($urandom_range(0, 3));
            id_rs3_addr  = 5'($urandom_range(0, 3));
            id_rs1_float = 1'($urandom);
            id_rs2_float = 1'($urandom);
            id_rs3_used  = 1'($urandom);
            ex_rd_addr   = 5'($urandom_range(0, 3));
            ex_regW_en   = 1'($urandom);
            ex_rsW_float = 1'($urandom);
            ex_mem_rd    = 1'($urandom);
            ex_fpu_op    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ex_redirect  = ($urandom_range(0, 5) == 0);
            @(negedge clk);

            e_start = 0; e_busy = 0; e_valid = 0;
            if (busy_left > 0) e_busy = 1;
            else if (done_pend) e_valid = 1;
            else if (ex_fpu_op == 2'b01 || ex_fpu_op == 2'b10) begin e_start = 1; e_busy = 1; end

            srcs_fp[0] = id_rs1_float; srcs_ad[0] = id_rs1_addr; srcs_on[0] = 1;
            srcs_fp[1] = id_rs2_float; srcs_ad[1] = id_rs2_addr; srcs_on[1] = 1;
            srcs_fp[2] = 1;            srcs_ad[2] = id_rs3_addr; srcs_on[2] = id_rs3_used;
            hit = 0;
            if (ex_mem_rd && ex_regW_en && !(ex_rsW_float == 0 && ex_rd_addr == 0))
                for (int s = 0; s < 3; s++)
                    if (srcs_on[s] && srcs_fp[s] == ex_rsW_float && srcs_ad[s] == ex_rd_addr) hit = 1;

            if (e_busy) want = e_start ? V_START : V_BUSY;
            else if (ex_redirect) want = V_REDIR | {9'b0, e_valid};
            else if (hit) want = V_LDUSE | {9'b0, e_valid};
            else want = V_RUN | {9'b0, e_valid};

            if (obs !== want) begin
                n_fail++; $display("FAIL random_cycle_%0d: got %b want %b", c, obs, want);
            end
            n_checks++;
`ifdef HAZ_STALL_CNT_EN
            if (stall_cycles !== 32'(stalls)) begin
                n_fail++; $display("FAIL random_stall_cnt_%0d: got %0d want %0d", c, stall_cycles, stalls);
            end
`else
            if (stall_cycles !== 32'd0) begin
                n_fail++; $display("FAIL random_stall_cnt_%0d: got %0d want 0", c, stall_cycles);
            end
`endif
            n_checks++;

            if (want[9] == 1'b0 && stalls < 64'hFFFF_FFFF) stalls++;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) done_pend = 1;
            end else if (done_pend) begin
                done_pend = 0;
            end else if (e_start) begin
                busy_left = ((ex_fpu_op == 2'b01) ? FDIV_LAT : FSQRT_LAT) - 2;
            end
        end
        next_cycle();
        drive_idle();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_load_use();
        test_fdiv();
        test_redirect_priority();
        test_reset_mid_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and multi-cycle FPU sequencer for the 5-stage RV32F core. It sits beside the IF_ID, ID_EX and EX_MEM pipeline registers and drives their enable/flush inputs. It resolves three conditions: load-use stalls (integer and float register classes), taken branch/jump redirects, and freezing the pipe while an iterative FDIV/FSQRT occupies EX. It also issues start/valid strobes to the iterative FPU divider/sqrt unit.

## Interface
- FDIV_CYCLES, 12, total EX occupancy of FDIV.S in cycles (>=3)
- FSQRT_CYCLES, 16, total EX occupancy of FSQRT.S in cycles (>=3)
- CNT_W, 5, width of occupancy counter (must hold max(FDIV_CYCLES,FSQRT_CYCLES)-2)
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- id_rs1_addr / id_rs2_addr / id_rs3_addr  in  5 each  ID source register indices
- id_rs1_float / id_rs2_float  in  1 each  source reads FP regfile
- id_rs3_used  in  1  ID instruction is R4-type (rs3 always FP)
- ex_rd_addr  in  5  EX destination index
- ex_regW_en  in  1  EX writes a register
- ex_rsW_float  in  1  EX destination is FP regfile
- ex_mem_rd  in  1  EX is a load (FLW or LW)
- ex_fpu_op  in  2  00 none/single-cycle, 01 FDIV, 10 FSQRT, 11 reserved (treated as 00)
- ex_redirect  in  1  branch taken or jump in EX
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  bubble insertion
- fpu_start  out  1  one-cycle kick to iterative unit
- fpu_busy  out  1  FPU-induced stall active
- fpu_result_valid  out  1  iterative result ready, EX advances this cycle
- stall_cycles  out  32  stall counter (see Configuration)

## Operation
- FSM states: IDLE, BUSY, DONE; 2-bit state reg, CNT_W-bit cnt.
- IDLE, ex_fpu_op in {01,10}: fpu_start=1, fpu_busy=1; cnt <= LAT-2 (LAT per op); next BUSY.
- BUSY: fpu_busy=1; cnt==1 -> DONE, else cnt <= cnt-1.
- DONE: fpu_result_valid=1, no stall; next IDLE unconditionally (no re-trigger from same op).
- FPU stall (fpu_busy=1): pc_en=if_id_en=id_ex_en=ex_mem_en=0, ex_mem_flush=1; all other flushes 0.
- Redirect (ex_redirect, no FPU stall): if_id_flush=1, id_ex_flush=1, all enables 1.
- Load-use (no FPU stall, no redirect): ex_mem_rd & ex_regW_en & match -> pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en=1, ex_mem_en=1.
- Match: rs1 (id_rs1_float==ex_rsW_float, addr equal); rs2 likewise; rs3 if id_rs3_used and ex_rsW_float. Integer x0 never matches; FP f0 does.
- Priority: FPU stall > redirect > load-use > run (all enables 1, flushes 0).
- All enable/flush/strobe outputs combinational from state and inputs.

## Timing
- Reset (async assert, sync release): state=IDLE, cnt=0, stall_cycles=0. Outputs with idle inputs: all enables 1, all flushes 0, fpu_start=0, fpu_busy=0, fpu_result_valid=0.
- FDIV with LAT=12: detect cycle + 10 BUSY + 1 DONE; EX/MEM captures the result at the end of cycle 12; 11 stall cycles.
- LAT=3: BUSY lasts exactly one cycle.
- Load-use: exactly one bubble; next cycle the load is in MEM, so no match.
- Reset mid-BUSY: immediate return to IDLE; no fpu_result_valid.
- Redirect and load-use in the same cycle: redirect wins, pc_en=1.

## Configuration
- HAZ_STALL_CNT_EN defined: stall_cycles increments by 1 each cycle pc_en==0, saturating at 32'hFFFFFFFF, and resets to 0.
- HAZ_STALL_CNT_EN undefined: stall_cycles tied to 0 and no counter flops.

## Test plan
- Reset, no hazards -> enables 1, flushes 0, stall_cycles=0.
- LW x5 in EX, ADD x6,x5,x7 in ID -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; then normal flow.
- FLW f5 in EX, ADD using x5 in ID -> no stall (class mismatch). LW x0 in EX with rs1=x0 -> no stall.
- FDIV in EX (FDIV_CYCLES=12) -> fpu_start in cycle 1, fpu_busy for 11 cycles, fpu_result_valid in cycle 12, ex_mem_flush=1 for 11 cycles. HAZ_STALL_CNT_EN build: stall_cycles=11.
- ex_redirect together with a load-use match -> if_id_flush=id_ex_flush=1, pc_en=1.
- rst low in 5th BUSY cycle of FSQRT -> state IDLE, fpu_busy=0, no fpu_result_valid after release.
